// File: rtl/bat_mem_pkg.sv
// Shared types and width defaults for the memory bus sequencer.
package bat_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_RWAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/bus_tristate_driver.sv
// Tri-state driver for the shared memory data bus; returns the resolved bus value.
module bus_tristate_driver #(
    parameter int unsigned W = 16
) (
    input  logic         drive_en,
    input  logic [W-1:0] dout,
    inout  wire  [W-1:0] bus,
    output logic [W-1:0] data_in
);

    assign bus     = drive_en ? dout : {W{1'bz}};
    assign data_in = bus;

endmodule

// File: rtl/mem_bus_sequencer.sv
// Turns single-word core requests into the memory pin sequence and returns
// completion/read data on a valid/ready response channel.
module mem_bus_sequencer
    import bat_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic              mem_enable,
    output logic              mem_output_en,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                drive_q;
    logic                ready_d, valid_d, load_d, enable_d, oe_d, drive_d;
    logic [DATA_W-1:0]   data_in;

    bus_tristate_driver #(.W(DATA_W)) u_drv (
        .drive_en (drive_q),
        .dout     (wdata_q),
        .bus      (mem_data),
        .data_in  (data_in)
    );

    // Next state plus next value of every registered output, decoded from state_d
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        addr_d  = mem_address;
        rdata_d = resp_rdata;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_W'(READ_LAT - 1);
                state_d = we_q ? ST_WRITE : ST_RWAIT;
            end
            ST_WRITE: begin
                rdata_d = '0;
                state_d = ST_RESP;
            end
            ST_RWAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = data_in;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d  = (state_d == ST_IDLE);
        valid_d  = (state_d == ST_RESP);
        load_d   = (state_d == ST_WRITE);
        enable_d = (state_d == ST_SETUP) || (state_d == ST_WRITE) || (state_d == ST_RWAIT);
        // Drive and output_en are mutually exclusive because they key off we_d
        oe_d     = ((state_d == ST_SETUP) && !we_d) || (state_d == ST_RWAIT);
        drive_d  = ((state_d == ST_SETUP) && we_d) || (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            mem_address   <= '0;
            resp_rdata    <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            mem_load      <= 1'b0;
            mem_enable    <= 1'b0;
            mem_output_en <= 1'b0;
            drive_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            mem_address   <= addr_d;
            resp_rdata    <= rdata_d;
            req_ready     <= ready_d;
            resp_valid    <= valid_d;
            mem_load      <= load_d;
            mem_enable    <= enable_d;
            mem_output_en <= oe_d;
            drive_q       <= drive_d;
        end
    end

endmodule
